ram_loader: RTL and testbench

//  Upstream write sequencer for p_ram. Takes a base address and a word count,

---
 rtl/ram_loader_pkg.sv | 12 +
 rtl/ram_loader_wrap_counter.sv | 28 ++
 rtl/ram_loader.sv | 115 +++++++++++
 tb/tb_ram_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types for the RAM write sequencer.
// Holds the loader FSM state encoding.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_loader_wrap_counter.sv
// wrap_counter: loadable up-counter, wraps modulo 2**WIDTH.
// Ports: clk, rst_n (sync), i_load/i_load_val, i_en, o_count.
module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_loader.sv
// ram_loader: stream/zero-fill write sequencer for p_ram.
// Ports: job ctrl (start/clear/abort/base/count), s_* stream, ram_* writes, busy/done/words_written.
import ram_loader_pkg::*;

module ram_loader #(
  parameter int BIT_WIDTH = 4,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 abort,
  input  logic [SEL_WIDTH-1:0] base,
  input  logic [SEL_WIDTH:0]   count,
  input  logic                 s_valid,
  input  logic [BIT_WIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic [SEL_WIDTH-1:0] ram_address,
  output logic [BIT_WIDTH-1:0] ram_in,
  output logic                 ram_load,
  output logic                 busy,
  output logic                 done,
  output logic [SEL_WIDTH:0]   words_written
);

  localparam logic [SEL_WIDTH:0] ONE = (SEL_WIDTH+1)'(1);

  state_t               r_state;
  logic [SEL_WIDTH:0]   r_remaining;
  logic [SEL_WIDTH-1:0] w_ptr;
  logic                 w_start;
  logic                 w_write;

  assign w_start = (r_state == ST_IDLE) && start;

  // abort wins over a handshake in the same cycle
  assign w_write = !abort &&
                   (((r_state == ST_FILL) && s_valid && s_ready) ||
                    (r_state == ST_CLEAR));

  wrap_counter #(
    .WIDTH (SEL_WIDTH)
  ) u_ptr (
    .clk        (clock),
    .rst_n      (reset),
    .i_load     (w_start),
    .i_load_val (base),
    .i_en       (w_write),
    .o_count    (w_ptr)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      s_ready       <= 1'b0;
      ram_address   <= '0;
      ram_in        <= '0;
      ram_load      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      ram_load <= 1'b0;
      done     <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining   <= count;
            words_written <= '0;
            if (count == '0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else if (clear) begin
              r_state <= ST_CLEAR;
              busy    <= 1'b1;
            end else begin
              r_state <= ST_FILL;
              busy    <= 1'b1;
              s_ready <= 1'b1;
            end
          end
        end
        ST_FILL, ST_CLEAR: begin
          if (abort) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b0;
          end else if (w_write) begin
            ram_address   <= w_ptr;
            ram_in        <= (r_state == ST_FILL) ? s_data : '0;
            ram_load      <= 1'b1;
            r_remaining   <= r_remaining - ONE;
            words_written <= words_written + ONE;
            // final write: done lines up with its ram_load
            if (r_remaining == ONE) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              s_ready <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader driving a p_ram stand-in.
// Reference: per-job write list (base+i mod depth) and expected memory image.
module tb_ram_loader;

  localparam int BW    = 4;
  localparam int SW    = 4;
  localparam int DEPTH = 16;

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic          start   = 1'b0;
  logic          clear   = 1'b0;
  logic          abort   = 1'b0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] base    = '0;
  logic [SW:0]   count   = '0;
  logic [BW-1:0] s_data  = '0;
  logic          s_ready;
  logic [SW-1:0] ram_address;
  logic [BW-1:0] ram_in;
  logic          ram_load;
  logic          busy;
  logic          done;
  logic [SW:0]   words_written;

  logic [BW-1:0] ram [DEPTH];
  int            exp_mem [DEPTH];
  int            n_chk  = 0;
  int            n_pass = 0;

  ram_loader #(
    .BIT_WIDTH (BW),
    .SEL_WIDTH (SW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .clear         (clear),
    .abort         (abort),
    .base          (base),
    .count         (count),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ram_address   (ram_address),
    .ram_in        (ram_in),
    .ram_load      (ram_load),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (ram_load) ram[ram_address] <= ram_in;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem[%0d]", i), 32'(ram[i]), exp_mem[i]);
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random
  // dmode: 0 random, 1 index, 2 constant 5
  // kill_at: handshake count at which to abort/reset (-1 none)
  task automatic run_job(input bit clr, input int b, input int c,
                         input int vmode, input int dmode,
                         input int kill_at, input bit kill_rst);
    int n;
    bit v;
    bit hs;
    bit killed;
    int a;
    logic [BW-1:0] d;
    n = 0;
    killed = 0;
    start = 1; clear = clr; abort = 0; s_valid = 0;
    base = SW'(b); count = (SW+1)'(c);
    @(negedge clock);
    start = 0;
    chk("start_ww", 32'(words_written), 0);
    chk("start_busy", 32'(busy), 32'(c != 0));
    chk("start_rdy", 32'(s_ready), 32'(c != 0 && !clr));
    chk("start_done", 32'(done), 32'(c == 0));
    for (int cyc = 0; cyc < 200 && n < c; cyc++) begin
      start = 1'($urandom); clear = 1'($urandom);
      base = SW'($urandom); count = (SW+1)'($urandom);
      if (n == kill_at) begin
        s_valid = 1; s_data = BW'($urandom);
        if (kill_rst) reset = 0;
        else abort = 1;
        @(negedge clock);
        reset = 1; abort = 0; start = 0; s_valid = 0;
        chk("kill_load", 32'(ram_load), 0);
        chk("kill_busy", 32'(busy), 0);
        chk("kill_rdy", 32'(s_ready), 0);
        chk("kill_done", 32'(done), 0);
        chk("kill_ww", 32'(words_written), kill_rst ? 0 : n);
        if (kill_rst) begin
          chk("rst_addr", 32'(ram_address), 0);
          chk("rst_in", 32'(ram_in), 0);
        end
        killed = 1;
        break;
      end
      case (vmode)
        0:       v = 1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom);
      endcase
      case (dmode)
        1:       d = n[BW-1:0];
        2:       d = BW'(5);
        default: d = BW'($urandom);
      endcase
      s_valid = v; s_data = d;
      hs = clr || v;
      @(negedge clock);
      if (hs) begin
        a = (b + n) % DEPTH;
        chk("load", 32'(ram_load), 1);
        chk("addr", 32'(ram_address), a);
        chk("data", 32'(ram_in), clr ? 0 : 32'(d));
        exp_mem[a] = clr ? 0 : int'(d);
        n++;
      end else begin
        chk("stall_load", 32'(ram_load), 0);
      end
      chk("done", 32'(done), 32'(n == c));
      chk("busy", 32'(busy), 32'(n < c));
      chk("rdy", 32'(s_ready), 32'(!clr && n < c));
      chk("ww", 32'(words_written), n);
    end
    s_valid = 0; abort = 0; clear = 0;
    if (killed) begin
      start = 0;
      @(negedge clock);
      chk("post_kill_done", 32'(done), 0);
      chk("post_kill_ww", 32'(words_written), kill_rst ? 0 : n);
    end else begin
      if (n < c) chk("timeout", n, c);
      // start during DONE must be ignored
      start = 1; count = (SW+1)'(5);
      @(negedge clock);
      start = 0;
      chk("end_done", 32'(done), 0);
      chk("end_busy", 32'(busy), 0);
      chk("end_rdy", 32'(s_ready), 0);
      chk("end_load", 32'(ram_load), 0);
      chk("end_ww", 32'(words_written), c);
    end
    check_mem();
  endtask

  initial begin
    int c;
    int k;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;
    reset = 0; start = 1; count = (SW+1)'(5);
    repeat (2) @(negedge clock);
    chk("rst_rdy", 32'(s_ready), 0);
    chk("rst_load", 32'(ram_load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ww", 32'(words_written), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_in", 32'(ram_in), 0);
    reset = 1; start = 0;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 0);

    run_job(0, 0, 16, 0, 1, -1, 0);
    run_job(0, 14, 4, 1, 0, -1, 0);
    run_job(0, 0, 16, 0, 2, -1, 0);
    run_job(1, 3, 5, 2, 0, -1, 0);
    run_job(0, 9, 8, 0, 0, 2, 0);
    run_job(0, 6, 0, 0, 0, -1, 0);
    run_job(1, 2, 0, 0, 0, -1, 0);
    run_job(0, 11, 8, 0, 0, 3, 1);
    run_job(0, 5, 6, 2, 0, -1, 0);

    for (int j = 0; j < 20; j++) begin
      c = $urandom_range(16);
      k = ($urandom_range(3) == 0 && c > 0) ? $urandom_range(c - 1) : -1;
      run_job(1'($urandom), $urandom_range(15), c, 2, 0, k,
              1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
